// File: rtl/data_mem_responder.sv
// Word-addressed 32-bit data memory responder with a fixed number of wait states
// between request acceptance and response; out-of-range accesses report an error.
module data_mem_responder #(
  parameter int ADDR_W      = 12,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [1:0]  dbg_state
);

  localparam int DEPTH = 1 << ADDR_W;

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // a response transfers on a rising edge where rsp_valid && rsp_ready. Each
  // side holds its payload stable while valid is high and ready is low.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        lat_we;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [31:0] mem [DEPTH];

  logic              accept;
  logic              enter_resp;
  logic              cur_we;
  logic [31:0]       cur_addr;
  logic [31:0]       cur_wdata;
  logic              in_range;
  logic [ADDR_W-1:0] idx;

  // With zero wait states RESP is entered on the acceptance edge itself, so the
  // access must use the live request rather than the not-yet-latched copy.
  always_comb begin
    cur_we    = lat_we;
    cur_addr  = lat_addr;
    cur_wdata = lat_wdata;
    if (state_q == IDLE) begin
      cur_we    = req_we;
      cur_addr  = req_addr;
      cur_wdata = req_wdata;
    end
  end

  assign in_range = ((cur_addr >> ADDR_W) == 32'd0);
  assign idx      = cur_addr[ADDR_W-1:0];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    accept     = 1'b0;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(WAIT_CYCLES);
          end
        end
      end
      WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d    = RESP;
          enter_resp = 1'b1;
          cnt_d      = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      lat_we    <= 1'b0;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
      rdata_q   <= 32'd0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        lat_we    <= req_we;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
      end
      if (enter_resp) begin
        rdata_q <= (!cur_we && in_range) ? mem[idx] : 32'd0;
        err_q   <= !in_range;
      end
    end
  end

  // Array is never cleared; writes are blocked while reset is held so an
  // abandoned transaction cannot commit.
  always_ff @(posedge clk) begin
    if (rst_n && enter_resp && cur_we && in_range) begin
      mem[idx] <= cur_wdata;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a transaction-level model.
module tb_data_mem_responder;

  localparam int ADDR_W = 12;
  localparam int W      = 2;

  logic        clk;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [1:0]  dbg_state;

  logic        req_valid0, req_ready0, req_we0;
  logic [31:0] req_addr0, req_wdata0;
  logic        rsp_valid0, rsp_ready0, rsp_err0;
  logic [31:0] rsp_rdata0;
  logic [1:0]  dbg_state0;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  data_mem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .dbg_state(dbg_state)
  );

  data_mem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we0),
    .req_addr(req_addr0), .req_wdata(req_wdata0),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0), .rsp_rdata(rsp_rdata0),
    .rsp_err(rsp_err0), .dbg_state(dbg_state0)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: act=%h exp=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // One outstanding transaction; the response is due W cycles after the
  // acceptance edge, the store lands when it becomes visible.
  logic [31:0] mem_m [int unsigned];
  bit          m_busy = 0, m_done = 0, e_known = 0;
  int          m_resp_at = 0;
  logic        m_we;
  logic [31:0] m_addr, m_wdata, e_rdata;
  logic        e_err;

  always @(negedge clk) begin
    if (m_busy && !m_done && cyc >= m_resp_at) begin
      m_done = 1;
      if (m_addr >= 32'(1 << ADDR_W)) begin
        e_err = 1'b1; e_rdata = 32'd0; e_known = 1;
      end else if (m_we) begin
        mem_m[m_addr] = m_wdata;
        e_err = 1'b0; e_rdata = 32'd0; e_known = 1;
      end else begin
        e_err   = 1'b0;
        e_known = mem_m.exists(m_addr);
        e_rdata = e_known ? mem_m[m_addr] : 32'd0;
      end
    end
    if (!rst_n) begin
      m_busy = 0;
      chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset_rsp_rdata", rsp_rdata, 32'd0);
      chk("reset_rsp_err", 32'(rsp_err), 32'd0);
    end else begin
      chk("req_ready", 32'(req_ready), 32'(!m_busy));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_busy && m_done));
      if (m_busy && m_done) begin
        chk("rsp_err", 32'(rsp_err), 32'(e_err));
        if (e_known) chk("rsp_rdata", rsp_rdata, e_rdata);
        if (rsp_ready) m_busy = 0;
      end else if (!m_busy && req_valid) begin
        m_busy = 1; m_done = 0;
        m_resp_at = cyc + 1 + W;
        m_we = req_we; m_addr = req_addr; m_wdata = req_wdata;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input int hold, output logic [31:0] rdata, output logic err,
                        output int lat);
    int acc, guard;
    lat = -1; rdata = 32'd0; err = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    rsp_ready = (hold == 0);
    guard = 0;
    do begin @(negedge clk); guard++; end while (!req_ready && guard < 50);
    if (!req_ready) begin
      chk("accept_timeout", 32'(req_ready), 32'd1);
      @(posedge clk); #1; req_valid = 1'b0;
      return;
    end
    acc = cyc + 1;
    @(posedge clk); #1; req_valid = 1'b0;
    guard = 0;
    do begin @(negedge clk); guard++; end while (!rsp_valid && guard < 50);
    if (!rsp_valid) begin
      chk("rsp_timeout", 32'(rsp_valid), 32'd1);
      return;
    end
    lat = cyc - acc + 1;
    rdata = rsp_rdata; err = rsp_err;
    for (int k = 1; k < hold; k++) begin
      @(negedge clk);
      chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rsp_rdata", rsp_rdata, rdata);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    if (hold > 0) begin
      @(posedge clk); #1; rsp_ready = 1'b1;
    end
    @(posedge clk); #1; rsp_ready = 1'b0;
  endtask

  task automatic store_reset_in_wait(input logic [31:0] addr, input logic [31:0] wdata);
    int guard, seen;
    @(posedge clk); #1;
    rsp_ready = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_addr = addr; req_wdata = wdata;
    guard = 0;
    do begin @(negedge clk); guard++; end while (!req_ready && guard < 50);
    @(posedge clk); #1;
    req_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    @(posedge clk); #1; rst_n = 1'b1;
    seen = 0;
    repeat (6) begin @(negedge clk); if (rsp_valid) seen++; end
    chk("rstwait_no_rsp", 32'(seen), 32'd0);
    chk("rstwait_ready", 32'(req_ready), 32'd1);
  endtask

  task automatic store_reset_in_resp(input logic [31:0] addr, input logic [31:0] wdata);
    int guard;
    @(posedge clk); #1;
    rsp_ready = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_addr = addr; req_wdata = wdata;
    guard = 0;
    do begin @(negedge clk); guard++; end while (!req_ready && guard < 50);
    @(posedge clk); #1; req_valid = 1'b0;
    guard = 0;
    do begin @(negedge clk); guard++; end while (!rsp_valid && guard < 50);
    chk("rstresp_reached", 32'(rsp_valid), 32'd1);
    @(posedge clk); #1; rst_n = 1'b0;
    @(negedge clk);
    chk("rstresp_dropped", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
  endtask

  task automatic run_w0();
    logic [31:0] a [3];
    logic [31:0] d [3];
    logic        w [3];
    logic [31:0] er [3];
    logic        ee [3];
    int acc [3];
    int guard;
    a  = '{32'h3, 32'h3, 32'h1003};
    d  = '{32'hCAFE0003, 32'h0, 32'h0};
    w  = '{1'b1, 1'b0, 1'b0};
    er = '{32'h0, 32'hCAFE0003, 32'h0};
    ee = '{1'b0, 1'b0, 1'b1};
    @(posedge clk); #1;
    rsp_ready0 = 1'b1; req_valid0 = 1'b1;
    req_we0 = w[0]; req_addr0 = a[0]; req_wdata0 = d[0];
    for (int n = 0; n < 3; n++) begin
      guard = 0;
      do begin @(negedge clk); guard++; end while (!req_ready0 && guard < 20);
      if (!req_ready0) begin
        chk("w0_accept_timeout", 32'(req_ready0), 32'd1);
        break;
      end
      chk("w0_idle_no_rsp", 32'(rsp_valid0), 32'd0);
      acc[n] = cyc + 1;
      @(posedge clk); #1;
      if (n < 2) begin
        req_we0 = w[n+1]; req_addr0 = a[n+1]; req_wdata0 = d[n+1];
      end else begin
        req_valid0 = 1'b0;
      end
      @(negedge clk);
      chk("w0_rsp_valid_lat1", 32'(rsp_valid0), 32'd1);
      chk("w0_rsp_rdata", rsp_rdata0, er[n]);
      chk("w0_rsp_err", 32'(rsp_err0), 32'(ee[n]));
      if (n > 0) chk("w0_accept_spacing", 32'(acc[n] - acc[n-1]), 32'd2);
    end
    @(posedge clk); #1; rsp_ready0 = 1'b0; req_valid0 = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat, r;
    rst_n = 1'b1;
    req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; rsp_ready = 0;
    req_valid0 = 0; req_we0 = 0; req_addr0 = 0; req_wdata0 = 0; rsp_ready0 = 0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_req_ready", 32'(req_ready), 32'd1);
    chk("post_reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("post_reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("post_reset_rsp_err", 32'(rsp_err), 32'd0);

    for (int i = 0; i < 16; i++) do_txn(1'b1, 32'(i), $urandom, 0, rd, er, lat);

    do_txn(1'b1, 32'h5, 32'hDEADBEEF, 0, rd, er, lat);
    chk("sw5_lat", 32'(lat), 32'd3);
    chk("sw5_rdata", rd, 32'd0);
    chk("sw5_err", 32'(er), 32'd0);
    do_txn(1'b0, 32'h5, 32'd0, 0, rd, er, lat);
    chk("lw5_lat", 32'(lat), 32'd3);
    chk("lw5_rdata", rd, 32'hDEADBEEF);
    chk("lw5_err", 32'(er), 32'd0);

    do_txn(1'b0, 32'h5, 32'd0, 4, rd, er, lat);
    chk("hold_lw5_rdata", rd, 32'hDEADBEEF);

    do_txn(1'b1, 32'h0, 32'hA5A50000, 0, rd, er, lat);
    do_txn(1'b1, 32'h1000, 32'h55555555, 0, rd, er, lat);
    chk("oor_err", 32'(er), 32'd1);
    chk("oor_rdata", rd, 32'd0);
    chk("oor_lat", 32'(lat), 32'd3);
    do_txn(1'b0, 32'h0, 32'd0, 0, rd, er, lat);
    chk("lw0_unchanged", rd, 32'hA5A50000);

    do_txn(1'b1, 32'h7, 32'h11110007, 0, rd, er, lat);
    store_reset_in_wait(32'h7, 32'h1234);
    do_txn(1'b0, 32'h7, 32'd0, 0, rd, er, lat);
    chk("lw7_after_abort", rd, 32'h11110007);

    store_reset_in_resp(32'h9, 32'h99990009);
    do_txn(1'b0, 32'h9, 32'd0, 0, rd, er, lat);
    chk("lw9_after_resp_reset", rd, 32'h99990009);

    run_w0();

    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      req_valid = 1'($urandom_range(0, 1));
      req_we    = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 9);
      if (r < 7)       req_addr = 32'($urandom_range(0, 15));
      else if (r == 7) req_addr = 32'hFFF;
      else if (r == 8) req_addr = 32'h1000 | 32'($urandom_range(0, 15));
      else             req_addr = $urandom;
      req_wdata = $urandom;
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    req_valid = 1'b0; rsp_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
